cycle_sequencer: RTL and testbench



---
 rtl/tb4004_timing_pkg.sv | 30 +++
 rtl/cycle_sequencer_tick_divider.sv | 34 +++
 rtl/cycle_sequencer.sv | 148 ++++++++++++++
 tb/tb_cycle_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tb4004_timing_pkg.sv
// Shared timing definitions for the TB4004 core: phase and sequencer state
// encodings plus the default divider speed constants.
package tb4004_timing_pkg;

    localparam int          DIV_W_DEF = 24;
    localparam int          CYC_W_DEF = 16;
    localparam logic [23:0] SPEED_MAX0 = 24'd3;
    localparam logic [23:0] SPEED_MAX1 = 24'd99;
    localparam logic [23:0] SPEED_MAX2 = 24'd99_999;
    localparam logic [23:0] SPEED_MAX3 = 24'd9_999_999;

    typedef enum logic [2:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/cycle_sequencer_tick_divider.sv
// Programmable tick divider: while enabled, pulses tick once every max+1 clocks;
// the counter is held cleared while disabled so each enable starts a fresh period.
module tick_divider
    import tb4004_timing_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] max,
    output logic             tick
);

    logic [DIV_W-1:0] r_count;
    logic             w_hit;

    assign w_hit = (r_count >= max);
    assign tick  = en & w_hit;

    // Period counter: clears on disable or on the tick that ends a period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {DIV_W{1'b0}};
        end else if (!en) begin
            r_count <= {DIV_W{1'b0}};
        end else if (w_hit) begin
            r_count <= {DIV_W{1'b0}};
        end else begin
            r_count <= r_count + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// Run/stop/single-step controller for the TB4004 instruction cycle; execution
// only ever halts on the X3 -> A1 boundary.
module cycle_sequencer
    import tb4004_timing_pkg::*;
#(
    parameter int               DIV_W = DIV_W_DEF,
    parameter logic [DIV_W-1:0] MAX0  = DIV_W'(SPEED_MAX0),
    parameter logic [DIV_W-1:0] MAX1  = DIV_W'(SPEED_MAX1),
    parameter logic [DIV_W-1:0] MAX2  = DIV_W'(SPEED_MAX2),
    parameter logic [DIV_W-1:0] MAX3  = DIV_W'(SPEED_MAX3),
    parameter int               CYC_W = CYC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       speed_sel,
    output logic             tick,
    output logic [2:0]       phase,
    output logic             sync,
    output logic             running,
    output logic [CYC_W-1:0] cyc_cnt
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_load_max;
    logic [DIV_W-1:0] r_max;
    logic [2:0]       r_phase;
    logic [CYC_W-1:0] r_cyc;
    logic             w_en;
    logic             w_tick;
    logic             w_x3_tick;

    function automatic logic [DIV_W-1:0] speed_max(input logic [1:0] sel);
        logic [DIV_W-1:0] v;
        case (sel)
            2'd0:    v = MAX0;
            2'd1:    v = MAX1;
            2'd2:    v = MAX2;
            2'd3:    v = MAX3;
            default: v = MAX0;
        endcase
        return v;
    endfunction

    assign w_en      = (r_state != IDLE);
    assign w_x3_tick = w_tick & (r_phase == PH_X3);

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_en),
        .max   (r_max),
        .tick  (w_tick)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: run beats step out of IDLE; STEP and DRAIN finish on the X3 tick.
    always_comb begin
        w_state_nxt = r_state;
        w_load_max  = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt = RUN;
                    w_load_max  = 1'b1;
                end else if (step) begin
                    w_state_nxt = STEP;
                    w_load_max  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (!run) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            STEP, DRAIN: begin
                if (run) begin
                    w_state_nxt = RUN;
                end else if (w_x3_tick) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Speed is latched only on leaving IDLE so a cycle never changes pace mid-flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max <= MAX0;
        end else if (w_load_max) begin
            r_max <= speed_max(speed_sel);
        end else begin
            r_max <= r_max;
        end
    end

    // Phase advance; pinned to A1 whenever the sequencer is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_A1;
        end else if (r_state == IDLE) begin
            r_phase <= PH_A1;
        end else if (w_tick) begin
            r_phase <= r_phase + 3'd1;
        end else begin
            r_phase <= r_phase;
        end
    end

    // Completed-cycle counter, bumped on the X3 tick and free to wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= {CYC_W{1'b0}};
        end else if (w_x3_tick) begin
            r_cyc <= r_cyc + {{(CYC_W-1){1'b0}}, 1'b1};
        end else begin
            r_cyc <= r_cyc;
        end
    end

    assign tick    = w_tick;
    assign phase   = r_phase;
    assign sync    = (r_phase == PH_X3);
    assign running = (r_state != IDLE);
    assign cyc_cnt = r_cyc;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: directed and randomized sessions
// compared against an arithmetic model of tick timing and stop boundaries.
`timescale 1ns/1ps
module tb_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step;
    logic [1:0]  speed_sel;
    logic        tick, sync, running;
    logic [2:0]  phase;
    logic [15:0] cyc_cnt;

    logic        run2, step2, tick2, sync2, running2;
    logic [2:0]  phase2;
    logic [3:0]  cyc2;

    int errors = 0;
    int checks = 0;
    int mon_ticks = 0, mon_ticks2 = 0;
    int mon_sync_bad = 0, mon_idle_tick = 0, mon_idle_phase = 0;
    logic [15:0] exp_cyc = 16'd0;
    bit run_w  [0:4095];
    bit step_w [0:4095];
    int period_tab [4] = '{4, 100, 100000, 10000000};

    always #5 clk = ~clk;

    cycle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .speed_sel(speed_sel),
        .tick(tick), .phase(phase), .sync(sync), .running(running), .cyc_cnt(cyc_cnt)
    );

    cycle_sequencer #(.MAX0(24'd0), .CYC_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .step(step2), .speed_sel(2'b00),
        .tick(tick2), .phase(phase2), .sync(sync2), .running(running2), .cyc_cnt(cyc2)
    );

    // Continuous observation of the invariants on both instances.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tick === 1'b1)  mon_ticks++;
            if (tick2 === 1'b1) mon_ticks2++;
            if (sync !== (phase == 3'd7))   mon_sync_bad++;
            if (sync2 !== (phase2 == 3'd7)) mon_sync_bad++;
            if (running !== 1'b1 && tick !== 1'b0)    mon_idle_tick++;
            if (running2 !== 1'b1 && tick2 !== 1'b0)  mon_idle_tick++;
            if (running !== 1'b1 && phase !== 3'd0)   mon_idle_phase++;
            if (running2 !== 1'b1 && phase2 !== 3'd0) mon_idle_phase++;
        end
    end

    task automatic clear_waves();
        for (int k = 0; k < 4096; k++) begin
            run_w[k]  = 1'b0;
            step_w[k] = 1'b0;
        end
    endtask

    // One session from IDLE. Edge j samples run_w[j]/step_w[j]. The model:
    // ticks fall every p clocks from the exit edge; the sequencer stops at the
    // first edge t = 8*m*p where run was low on edge t and edge t-1.
    task automatic run_session(input string name, input int sel0, input bit chg_speed);
        int p, t, m, bad_run, bad_tick, bad_phase;
        bit exp_run, exp_tick;
        logic [2:0] exp_ph;
        p = period_tab[sel0];
        t = -1;
        for (int k = 1; k * 8 * p < 4090; k++) begin
            if (t < 0 && run_w[k*8*p] == 1'b0 && run_w[k*8*p-1] == 1'b0) t = k * 8 * p;
        end
        m = t / (8 * p);
        bad_run = 0; bad_tick = 0; bad_phase = 0;
        for (int j = 0; j <= t + 2; j++) begin
            @(negedge clk);
            if (j == 0) begin
                mon_ticks = 0;
                speed_sel = 2'(sel0);
            end
            exp_run  = (j >= 1 && j <= t);
            exp_tick = exp_run && (j % p == 0);
            exp_ph   = exp_run ? 3'(((j - 1) / p) % 8) : 3'd0;
            if (running !== exp_run) bad_run++;
            if (tick !== exp_tick)   bad_tick++;
            if (phase !== exp_ph)    bad_phase++;
            run  = (j <= t) ? run_w[j] : 1'b0;
            step = (j < t) ? step_w[j] : 1'b0;
            if (chg_speed && j >= 1) speed_sel = 2'($urandom_range(0, 3));
        end
        run = 1'b0; step = 1'b0; speed_sel = 2'd0;
        exp_cyc = exp_cyc + 16'(m);
        checks++;
        if (bad_run != 0) begin errors++; $display("FAIL %s running: %0d bad samples, want 0", name, bad_run); end
        checks++;
        if (bad_tick != 0) begin errors++; $display("FAIL %s tick: %0d bad samples, want 0", name, bad_tick); end
        checks++;
        if (bad_phase != 0) begin errors++; $display("FAIL %s phase: %0d bad samples, want 0", name, bad_phase); end
        checks++;
        if (mon_ticks != 8 * m) begin errors++; $display("FAIL %s tick_count: got %0d want %0d", name, mon_ticks, 8 * m); end
        checks++;
        if (cyc_cnt !== exp_cyc) begin errors++; $display("FAIL %s cyc_cnt: got %0d want %0d", name, cyc_cnt, exp_cyc); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; step = 1'b0; speed_sel = 2'd0; run2 = 1'b0; step2 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (running !== 1'b0 || phase !== 3'd0 || tick !== 1'b0) begin
            errors++; $display("FAIL reset_hold: running=%b phase=%0d tick=%b want 0/0/0", running, phase, tick);
        end
        rst_n = 1'b1;
        mon_ticks = 0;
        repeat (20) @(negedge clk);
        checks++;
        if (mon_ticks != 0) begin errors++; $display("FAIL idle_ticks: got %0d want 0", mon_ticks); end
        checks++;
        if (phase !== 3'd0 || running !== 1'b0 || sync !== 1'b0) begin
            errors++; $display("FAIL idle_outputs: phase=%0d running=%b sync=%b want 0/0/0", phase, running, sync);
        end
        checks++;
        if (cyc_cnt !== 16'd0 || cyc2 !== 4'd0 || running2 !== 1'b0) begin
            errors++; $display("FAIL idle_counts: cyc=%0d cyc2=%0d running2=%b want 0/0/0", cyc_cnt, cyc2, running2);
        end
    endtask

    task automatic test_single_step();
        clear_waves(); step_w[0] = 1'b1;
        run_session("step_s0", 0, 1'b0);
    endtask

    task automatic test_run_stop();
        clear_waves();
        for (int k = 0; k <= 12; k++) run_w[k] = 1'b1;
        run_session("run_stop", 0, 1'b0);
        clear_waves();
        for (int k = 0; k <= 12; k++) run_w[k] = 1'b1;
        for (int k = 19; k <= 40; k++) run_w[k] = 1'b1;
        run_session("drain_reraise", 0, 1'b0);
    endtask

    task automatic test_priority_ignore();
        clear_waves();
        step_w[0] = 1'b1;
        for (int k = 0; k <= 20; k++) run_w[k] = 1'b1;
        step_w[5] = 1'b1; step_w[15] = 1'b1; step_w[25] = 1'b1; step_w[30] = 1'b1;
        run_session("run_step_same_clk", 0, 1'b1);
        clear_waves();
        step_w[0] = 1'b1; step_w[3] = 1'b1; step_w[10] = 1'b1; step_w[20] = 1'b1; step_w[31] = 1'b1;
        run_session("step_ignored", 0, 1'b1);
        clear_waves();
        step_w[0] = 1'b1;
        for (int k = 6; k <= 50; k++) run_w[k] = 1'b1;
        run_session("step_absorbed", 0, 1'b0);
    endtask

    task automatic test_speed1();
        clear_waves(); step_w[0] = 1'b1;
        run_session("step_s1", 1, 1'b0);
    endtask

    task automatic test_random();
        int len, g0, glen, a, b;
        for (int s = 0; s < 8; s++) begin
            clear_waves();
            if ($urandom_range(0, 1) == 1) begin
                len = $urandom_range(1, 90);
                for (int k = 0; k < len; k++) run_w[k] = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    g0 = $urandom_range(1, len); glen = $urandom_range(1, 6);
                    for (int k = g0; k < g0 + glen; k++) run_w[k] = 1'b0;
                end
                step_w[0] = 1'($urandom_range(0, 1));
            end else begin
                step_w[0] = 1'b1;
                if ($urandom_range(0, 1) == 1) begin
                    a = $urandom_range(1, 20); b = $urandom_range(1, 60);
                    for (int k = a; k <= a + b; k++) run_w[k] = 1'b1;
                end
            end
            for (int k = 1; k < 300; k++) if ($urandom_range(0, 9) == 0) step_w[k] = 1'b1;
            run_session($sformatf("random%0d", s), 0, 1'($urandom_range(0, 1)));
        end
    endtask

    // Second instance: MAX0=0 gives one tick per clock; 17 cycles wrap a 4-bit count to 1.
    task automatic test_wrap();
        int bad;
        bit er;
        bad = 0;
        for (int j = 0; j <= 138; j++) begin
            @(negedge clk);
            if (j == 0) mon_ticks2 = 0;
            er = (j >= 1 && j <= 136);
            if (running2 !== er || tick2 !== er) bad++;
            if (phase2 !== (er ? 3'((j - 1) % 8) : 3'd0)) bad++;
            run2 = (j <= 128);
        end
        run2 = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_timing: %0d bad samples, want 0", bad); end
        checks++;
        if (mon_ticks2 != 136) begin errors++; $display("FAIL wrap_ticks: got %0d want 136", mon_ticks2); end
        checks++;
        if (cyc2 !== 4'd1) begin errors++; $display("FAIL wrap_cyc_cnt: got %0d want 1", cyc2); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        speed_sel = 2'd0; run = 1'b1;
        repeat (22) @(negedge clk);
        checks++;
        if (phase !== 3'd5) begin errors++; $display("FAIL pre_reset_phase: got %0d want 5", phase); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (phase !== 3'd0 || running !== 1'b0 || tick !== 1'b0 || sync !== 1'b0) begin
            errors++; $display("FAIL async_reset_outputs: phase=%0d running=%b tick=%b sync=%b want 0/0/0/0", phase, running, tick, sync);
        end
        checks++;
        if (cyc_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_cyc: got %0d want 0", cyc_cnt); end
        run = 1'b0;
        exp_cyc = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_waves(); step_w[0] = 1'b1;
        run_session("post_reset_step", 0, 1'b0);
    endtask

    task automatic test_invariants();
        checks++;
        if (mon_sync_bad != 0) begin errors++; $display("FAIL sync_vs_phase: %0d bad samples, want 0", mon_sync_bad); end
        checks++;
        if (mon_idle_tick != 0) begin errors++; $display("FAIL tick_in_idle: %0d bad samples, want 0", mon_idle_tick); end
        checks++;
        if (mon_idle_phase != 0) begin errors++; $display("FAIL phase_in_idle: %0d bad samples, want 0", mon_idle_phase); end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_run_stop();
        test_priority_ignore();
        test_speed1();
        test_random();
        test_wrap();
        test_async_reset();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
